mux_rr_arbiter: RTL

//  Round-robin arbiter sharing one mux16_1 read path among 16 requesters.

---
 rtl/mux_rr_arbiter.sv | 87 ++++++++
 1 files changed

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin grant of one shared mux16_1 path among NUM_REQ requesters (optional hold timeout via ARB_TIMEOUT_EN)
module mux_rr_arbiter #(
  parameter int NUM_REQ  = 16,
  parameter int SEL_W    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               valid,
  output logic               timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [NUM_REQ-1:0] grant_n;
  logic [SEL_W-1:0] sel_n, ptr, ptr_n, win;
  logic valid_n, rel, stop;
  if (SEL_W != $clog2(NUM_REQ) || NUM_REQ != (1 << SEL_W) || MAX_HOLD < 1) begin : g_bad_cfg
    $error("mux_rr_arbiter: inconsistent NUM_REQ/SEL_W/MAX_HOLD");
  end
  assign rel = done | ~req[sel];
`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_cnt;
  logic expire;
  assign expire = hold_cnt == HW'(MAX_HOLD - 1);
  assign stop = rel | expire;
  // hold counter runs only while a grant is kept; timeout pulses on a forced release
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      hold_cnt <= (state == GRANT && !stop) ? hold_cnt + 1'b1 : '0;
      timeout  <= state == GRANT && !rel && expire;
    end
  end
`else
  assign stop = rel;
  assign timeout = 1'b0;
`endif
  // first requester at or after ptr, wrapping; lower offsets overwrite higher ones
  always_comb begin
    win = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[ptr + SEL_W'(i)]) win = ptr + SEL_W'(i);
  end
  // next state: grant from IDLE, release from GRANT (always via an idle bubble)
  always_comb begin
    state_n = state;
    grant_n = grant;
    sel_n   = sel;
    valid_n = valid;
    ptr_n   = ptr;
    if (state == IDLE && |req) begin
      state_n = GRANT;
      grant_n = NUM_REQ'(1) << win;
      sel_n   = win;
      valid_n = 1'b1;
    end else if (state == GRANT && stop) begin
      state_n = IDLE;
      grant_n = '0;
      sel_n   = '0;
      valid_n = 1'b0;
      ptr_n   = sel + 1'b1;
    end
  end
  // registered state and outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      sel   <= '0;
      valid <= 1'b0;
      ptr   <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      sel   <= sel_n;
      valid <= valid_n;
      ptr   <= ptr_n;
    end
  end
endmodule
